// File: rtl/vec_op_pkg.sv
// Shared definitions for the byte-shift vector pipeline: operation
// encoding and the default vector width.
package vec_op_pkg;

    typedef enum logic [1:0] {
        SRLI    = 2'b00,
        SLLI    = 2'b01,
        ALIGNR  = 2'b10,
        ILLEGAL = 2'b11
    } vec_mode_e;

    localparam int NBYTES_DEFAULT = 16;

endpackage

// File: rtl/vec_byte_shifter.sv
// Combinational byte shifter. The count arrives already clamped to at most
// 2*NBYTES, so any over-range count shifts every byte out and yields zero.
module vec_byte_shifter
    import vec_op_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT,
    parameter int CNT_W  = $clog2(2*NBYTES) + 1
) (
    input  logic [8*NBYTES-1:0] i_a,
    input  logic [8*NBYTES-1:0] i_b,
    input  logic [1:0]          i_mode,
    input  logic [CNT_W-1:0]    i_cnt,
    output logic [8*NBYTES-1:0] o_dst,
    output logic                o_err
);

    localparam int W = 8*NBYTES;

    logic [2*W-1:0]   w_cat;
    logic [W-1:0]     w_shr;
    logic [W-1:0]     w_shl;
    logic [CNT_W+2:0] w_bits;

    // SRLI is ALIGNR with a zero upper half, so both share one right shifter.
    assign w_bits = {i_cnt, 3'b000};
    assign w_cat  = (i_mode == ALIGNR) ? {i_a, i_b} : {{W{1'b0}}, i_a};
    assign w_shr  = W'(w_cat >> w_bits);
    assign w_shl  = i_a << w_bits;
    assign o_err  = (i_mode == ILLEGAL);

    // Select the shifted result by mode; the illegal mode produces zero.
    always_comb begin
        o_dst = '0;
        case (i_mode)
            SRLI, ALIGNR: o_dst = w_shr;
            SLLI:         o_dst = w_shl;
            default:      o_dst = '0;
        endcase
    end

endmodule

// File: rtl/vec_byte_shift_pipe.sv
// Two-stage byte-shift pipeline with valid/ready handshakes on both sides.
// S1 captures operands and the clamped count, S2 holds the shifted result.
module vec_byte_shift_pipe
    import vec_op_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT,
    parameter int TAG_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_mode,
    input  logic [7:0]          in_imm,
    input  logic [8*NBYTES-1:0] in_a,
    input  logic [8*NBYTES-1:0] in_b,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_dst,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err
);

    localparam int         W       = 8*NBYTES;
    localparam int         CNT_W   = $clog2(2*NBYTES) + 1;
    localparam logic [7:0] CNT_MAX = 8'(2*NBYTES);

    logic               r_s1_valid;
    logic [W-1:0]       r_s1_a;
    logic [W-1:0]       r_s1_b;
    logic [1:0]         r_s1_mode;
    logic [CNT_W-1:0]   r_s1_cnt;
    logic [TAG_W-1:0]   r_s1_tag;

    logic               r_s2_valid;
    logic [W-1:0]       r_s2_dst;
    logic [TAG_W-1:0]   r_s2_tag;
    logic               r_s2_err;

    logic               w_s2_load;
    logic               w_s1_load;
    logic [CNT_W-1:0]   w_cnt_clamp;
    logic [W-1:0]       w_shift_dst;
    logic               w_shift_err;

    // A stage may load when it is empty or its content leaves this cycle.
    assign w_s2_load   = !r_s2_valid || out_ready;
    assign w_s1_load   = !r_s1_valid || w_s2_load;
    assign in_ready    = rst_n && w_s1_load;

    // Counts of 2*NBYTES or more all behave identically (everything shifted
    // out), so they collapse to 2*NBYTES and keep the S1 count narrow.
    assign w_cnt_clamp = (in_imm >= CNT_MAX) ? CNT_MAX[CNT_W-1:0] : in_imm[CNT_W-1:0];

    vec_byte_shifter #(
        .NBYTES (NBYTES),
        .CNT_W  (CNT_W)
    ) u_shifter (
        .i_a    (r_s1_a),
        .i_b    (r_s1_b),
        .i_mode (r_s1_mode),
        .i_cnt  (r_s1_cnt),
        .o_dst  (w_shift_dst),
        .o_err  (w_shift_err)
    );

    // S1: capture the accepted operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_mode  <= '0;
            r_s1_cnt   <= '0;
            r_s1_tag   <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a    <= in_a;
                r_s1_b    <= in_b;
                r_s1_mode <= in_mode;
                r_s1_cnt  <= w_cnt_clamp;
                r_s1_tag  <= in_tag;
            end
        end
    end

    // S2: register the shifted result; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_dst   <= '0;
            r_s2_tag   <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_dst <= w_shift_dst;
                r_s2_tag <= r_s1_tag;
                r_s2_err <= w_shift_err;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_dst   = r_s2_dst;
    assign out_tag   = r_s2_tag;
    assign out_err   = r_s2_err;

endmodule

// File: tb/tb_vec_byte_shift_pipe.sv
// Testbench for vec_byte_shift_pipe: byte-level reference model, scoreboard
// compare on every output transfer, plus directed literal expectations.
module tb_vec_byte_shift_pipe;

    localparam int NB = 16;
    localparam int TW = 8;
    localparam int W  = 8*NB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_mode;
    logic [7:0]    in_imm;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_dst;
    logic [TW-1:0] out_tag;
    logic          out_err;

    typedef struct {
        logic [W-1:0]  dst;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    logic [TW-1:0] obs_tags[$];
    exp_t          e_pop;
    exp_t          e_new;
    int            checks = 0;
    int            errors = 0;

    logic          hold_vld = 1'b0;
    logic [W-1:0]  hold_dst;
    logic [TW-1:0] hold_tag;
    logic          hold_err;

    localparam logic [W-1:0] A_FA  = {NB{8'hfa}};
    localparam logic [W-1:0] A_HI  = 128'h1f1e1d1c_1b1a1918_17161514_13121110;
    localparam logic [W-1:0] B_LO  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [W-1:0] A_MIX = 128'h00112233_44556677_8899aabb_ccddeeff;

    vec_byte_shift_pipe #(
        .NBYTES (NB),
        .TAG_W  (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_imm    (in_imm),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dst   (out_dst),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    // Reference: each destination byte picked straight from the operand bytes.
    function automatic logic [W-1:0] model(input logic [1:0] m, input logic [7:0] imm,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        int im;
        int j;
        r  = '0;
        im = imm;
        for (int i = 0; i < NB; i++) begin
            case (m)
                2'b00: begin
                    j = i + im;
                    if (j < NB) r[8*i +: 8] = a[8*j +: 8];
                end
                2'b01: begin
                    j = i - im;
                    if (j >= 0) r[8*i +: 8] = a[8*j +: 8];
                end
                2'b10: begin
                    j = i + im;
                    if (j < NB) r[8*i +: 8] = b[8*j +: 8];
                    else if (j < 2*NB) r[8*i +: 8] = a[8*(j-NB) +: 8];
                end
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard: record accepted ops, compare every output transfer, and
    // require outputs to stay put across a stalled cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                chk_i("hold_valid", int'(out_valid), 1);
                chk_w("hold_dst", out_dst, hold_dst);
                chk_i("hold_tag", int'(out_tag), int'(hold_tag));
                chk_i("hold_err", int'(out_err), int'(hold_err));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=tag %0d required=no output", out_tag);
                end else begin
                    e_pop = exp_q.pop_front();
                    chk_w("model_dst", out_dst, e_pop.dst);
                    chk_i("model_tag", int'(out_tag), int'(e_pop.tag));
                    chk_i("model_err", int'(out_err), int'(e_pop.err));
                    obs_tags.push_back(out_tag);
                end
            end
            hold_vld = out_valid && !out_ready;
            hold_dst = out_dst;
            hold_tag = out_tag;
            hold_err = out_err;
            if (in_valid && in_ready) begin
                e_new.dst = model(in_mode, in_imm, in_a, in_b);
                e_new.tag = in_tag;
                e_new.err = (in_mode == 2'b11);
                exp_q.push_back(e_new);
            end
        end
    end

    // Entered just after a rising edge; returns just after the edge that accepted.
    task automatic push_op(input logic [1:0] m, input logic [7:0] imm,
                           input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag);
        logic acc;
        int   n;
        acc      = 1'b0;
        n        = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_imm   = imm;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk_i("push_accepted", int'(acc), 1);
    endtask

    // One op into an empty pipe with out_ready high; check latency and literal result.
    task automatic send_single(input string name, input logic [1:0] m, input logic [7:0] imm,
                               input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag,
                               input logic [W-1:0] req_dst, input logic req_err);
        int lat;
        int k;
        lat       = 0;
        k         = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = m;
        in_imm    = imm;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        @(negedge clk);
        chk_i({name, "_in_ready"}, int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        while (lat == 0 && k < 8) begin
            @(negedge clk);
            k++;
            if (out_valid) lat = k;
        end
        chk_i({name, "_latency"}, lat, 2);
        chk_w({name, "_dst"}, out_dst, req_dst);
        chk_i({name, "_err"}, int'(out_err), int'(req_err));
        chk_i({name, "_tag"}, int'(out_tag), int'(tag));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk_i("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 2'b00;
        in_imm    = 8'd0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        chk_w("model_pin_alignr4", model(2'b10, 8'd4, A_HI, B_LO),
              128'h13121110_0f0e0d0c_0b0a0908_07060504);
        chk_w("model_pin_slli3", model(2'b01, 8'd3, A_MIX, '0),
              128'h33445566_778899aa_bbccddee_ff000000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_i("rst_out_valid", int'(out_valid), 0);
        chk_i("rst_in_ready", int'(in_ready), 0);
        chk_w("rst_out_dst", out_dst, '0);
        chk_i("rst_out_tag", int'(out_tag), 0);
        chk_i("rst_out_err", int'(out_err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_i("release_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        send_single("srli15",   2'b00, 8'd15,  A_FA, '0, 8'h01, 128'h000000fa, 1'b0);
        send_single("slli15",   2'b01, 8'd15,  A_FA, '0, 8'h02, {8'hfa, 120'h0}, 1'b0);
        send_single("srli16",   2'b00, 8'd16,  A_FA, '0, 8'h03, '0, 1'b0);
        send_single("srli255",  2'b00, 8'd255, A_FA, '0, 8'h04, '0, 1'b0);
        send_single("slli16",   2'b01, 8'd16,  A_FA, '0, 8'h05, '0, 1'b0);
        send_single("alignr4",  2'b10, 8'd4,   A_HI, B_LO, 8'h06,
                    128'h13121110_0f0e0d0c_0b0a0908_07060504, 1'b0);
        send_single("alignr20", 2'b10, 8'd20,  A_HI, B_LO, 8'h07,
                    128'h00000000_1f1e1d1c_1b1a1918_17161514, 1'b0);
        send_single("alignr16", 2'b10, 8'd16,  A_HI, B_LO, 8'h08, A_HI, 1'b0);
        send_single("alignr0",  2'b10, 8'd0,   A_HI, B_LO, 8'h09, B_LO, 1'b0);
        send_single("alignr31", 2'b10, 8'd31,  A_HI, B_LO, 8'h0a, 128'h1f, 1'b0);
        send_single("alignr32", 2'b10, 8'd32,  A_HI, B_LO, 8'h0b, '0, 1'b0);
        send_single("illegal",  2'b11, 8'd7,   A_MIX, B_LO, 8'h0c, '0, 1'b1);
        send_single("srli1",    2'b00, 8'd1,   A_MIX, B_LO, 8'h0d,
                    128'h00001122_33445566_778899aa_bbccddee, 1'b0);
        send_single("slli3",    2'b01, 8'd3,   A_MIX, '0, 8'h0e,
                    128'h33445566_778899aa_bbccddee_ff000000, 1'b0);

        // Backpressure: two ops fill the pipe, then in_ready must drop.
        obs_tags.delete();
        out_ready = 1'b0;
        push_op(2'b00, 8'd2, A_MIX, '0, 8'd1);
        push_op(2'b01, 8'd5, A_MIX, '0, 8'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_i("full_in_ready", int'(in_ready), 0);
            chk_i("full_out_valid", int'(out_valid), 1);
            chk_i("full_out_tag", int'(out_tag), 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        push_op(2'b10, 8'd9, A_HI, B_LO, 8'd3);
        push_op(2'b11, 8'd1, A_HI, B_LO, 8'd4);
        drain();
        chk_i("tag_count", obs_tags.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < obs_tags.size()) chk_i($sformatf("tag_order%0d", i), int'(obs_tags[i]), i + 1);
        end

        // Random traffic against a randomly stalling consumer.
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    push_op(2'($urandom_range(0, 3)),
                            ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 33)),
                            {$urandom, $urandom, $urandom, $urandom},
                            {$urandom, $urandom, $urandom, $urandom},
                            8'(n + 8'h40));
                end
            end
            begin
                for (int n = 0; n < 150; n++) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with two ops in flight: nothing may come out afterwards.
        out_ready = 1'b0;
        push_op(2'b00, 8'd1, A_MIX, '0, 8'h21);
        push_op(2'b01, 8'd1, A_MIX, '0, 8'h22);
        rst_n = 1'b0;
        @(negedge clk);
        chk_i("midrst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_i("midrst_out_valid", int'(out_valid), 0);
        chk_i("midrst_in_ready_after", int'(in_ready), 1);
        chk_w("midrst_out_dst", out_dst, '0);
        chk_i("midrst_out_tag", int'(out_tag), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk_i("midrst_no_stale", int'(out_valid), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
